// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ids, switch port ids, route FSM states and
// dimension-order routing modes.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_TAIL     = 2'b01,
        FLIT_HEAD     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_id_e;

    localparam int unsigned PORT_RESOURCE = 0;
    localparam int unsigned PORT_LEFT     = 1;
    localparam int unsigned PORT_UP       = 2;
    localparam int unsigned PORT_RIGHT    = 3;
    localparam int unsigned PORT_DOWN     = 4;

    localparam int unsigned DOR_XY = 0;
    localparam int unsigned DOR_YX = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } route_state_e;

endpackage

// File: rtl/dor_route_calc.sv
// Combinational dimension-order route decode: destination address to output
// channel select for a node at (COL_CORD, ROW_CORD).
module dor_route_calc
    import noc_pkg::*;
#(
    parameter int unsigned COL_CORD   = 0,
    parameter int unsigned ROW_CORD   = 0,
    parameter int unsigned COL_ADDR_W = 4,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned OUT_N_W    = 3,
    parameter int unsigned DOR_MODE   = DOR_XY
) (
    input  logic [COL_ADDR_W-1:0] dest_col,
    input  logic [ROW_ADDR_W-1:0] dest_row,
    output logic [OUT_N_W-1:0]    chan_sel
);

    localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
    localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);

    logic [OUT_N_W-1:0] col_sel;
    logic [OUT_N_W-1:0] row_sel;
    logic               col_hit;
    logic               row_hit;

    always_comb begin
        col_sel = OUT_N_W'(PORT_RESOURCE);
        row_sel = OUT_N_W'(PORT_RESOURCE);
        col_hit = (dest_col == MY_COL);
        row_hit = (dest_row == MY_ROW);

        if (dest_col > MY_COL)
            col_sel = OUT_N_W'(PORT_RIGHT);
        else if (dest_col < MY_COL)
            col_sel = OUT_N_W'(PORT_LEFT);

        if (dest_row < MY_ROW)
            row_sel = OUT_N_W'(PORT_UP);
        else if (dest_row > MY_ROW)
            row_sel = OUT_N_W'(PORT_DOWN);

        // The first dimension wins whenever it still has distance to cover
        if (DOR_MODE == DOR_YX)
            chan_sel = row_hit ? col_sel : row_sel;
        else
            chan_sel = col_hit ? row_sel : col_sel;
    end

endmodule

// File: rtl/dor_route_unit.sv
// Per-input-port route controller: locks a dimension-order route on the head
// flit, holds it until the tail, and forwards flits through a valid/ready register.
module dor_route_unit
    import noc_pkg::*;
#(
    parameter int unsigned COL_CORD    = 0,
    parameter int unsigned ROW_CORD    = 0,
    parameter int unsigned COL_ADDR_W  = 4,
    parameter int unsigned ROW_ADDR_W  = 4,
    parameter int unsigned OUT_N_W     = 3,
    parameter int unsigned FLIT_DATA_W = 8,
    parameter int unsigned DOR_MODE    = DOR_XY
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [FLIT_DATA_W+1:0]   in_flit_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [FLIT_DATA_W+1:0]   out_flit_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_N_W-1:0]       out_chan_sel_o,
    output logic                     out_last_o,
    output logic                     pkt_active_o,
    output logic                     err_o
);

    route_state_e       state;
    flit_id_e           in_id;
    logic               accept;
    logic [OUT_N_W-1:0] route_sel;

    assign in_id      = flit_id_e'(in_flit_i[FLIT_DATA_W+1:FLIT_DATA_W]);
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    dor_route_calc #(
        .COL_CORD   (COL_CORD),
        .ROW_CORD   (ROW_CORD),
        .COL_ADDR_W (COL_ADDR_W),
        .ROW_ADDR_W (ROW_ADDR_W),
        .OUT_N_W    (OUT_N_W),
        .DOR_MODE   (DOR_MODE)
    ) u_route_calc (
        .dest_col (in_flit_i[COL_ADDR_W-1:0]),
        .dest_row (in_flit_i[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W]),
        .chan_sel (route_sel)
    );

    // out_chan_sel_o doubles as the route lock register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            out_chan_sel_o <= '0;
            out_flit_o     <= '0;
            out_valid_o    <= 1'b0;
            out_last_o     <= 1'b0;
            pkt_active_o   <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;

            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        case (in_id)
                            FLIT_HEAD, FLIT_HEADTAIL: begin
                                out_chan_sel_o <= route_sel;
                                out_flit_o     <= in_flit_i;
                                out_valid_o    <= 1'b1;
                                out_last_o     <= (in_id == FLIT_HEADTAIL);
                                if (in_id == FLIT_HEAD) begin
                                    state        <= ST_BUSY;
                                    pkt_active_o <= 1'b1;
                                end
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end
                    ST_BUSY: begin
                        case (in_id)
                            FLIT_BODY, FLIT_TAIL: begin
                                out_flit_o  <= in_flit_i;
                                out_valid_o <= 1'b1;
                                out_last_o  <= (in_id == FLIT_TAIL);
                                if (in_id == FLIT_TAIL) begin
                                    state        <= ST_IDLE;
                                    pkt_active_o <= 1'b0;
                                end
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
